// File: rtl/sram_match_engine_if.sv
// rtl/sram_match_engine_if.sv - request/result and SRAM status probe bundle for sram_match_engine
interface sram_match_engine_if #(
    parameter int IDX_W   = 5,
    parameter int SPACE_W = 11,
    parameter int AMT_W   = 9,
    parameter int LEN_W   = 6,
    parameter int TICK_W  = 8
);
    logic               match_req;
    logic               match_abort;
    logic [1:0]         mode;
    logic [LEN_W-1:0]   new_length;
    logic [TICK_W-1:0]  match_threshold;
    logic [TICK_W-1:0]  match_timeout;
    logic [IDX_W-1:0]   probe_sram;
    logic               accessible;
    logic [SPACE_W-1:0] free_space;
    logic [AMT_W-1:0]   packet_amount;
    logic               match_busy;
    logic               match_suc;
    logic               match_fail;
    logic [IDX_W:0]     match_best_sram;

    modport slave (
        input  match_req, match_abort, mode, new_length, match_threshold, match_timeout,
        input  accessible, free_space, packet_amount,
        output probe_sram, match_busy, match_suc, match_fail, match_best_sram
    );

    modport master (
        output match_req, match_abort, mode, new_length, match_threshold, match_timeout,
        output accessible, free_space, packet_amount,
        input  probe_sram, match_busy, match_suc, match_fail, match_best_sram
    );
endinterface

// File: rtl/sram_match_engine.sv
// rtl/sram_match_engine.sv - round-robin SRAM scan picking a destination by amount, space or first fit
module sram_match_engine #(
    parameter int NUM_SRAM = 32,
    parameter int IDX_W    = 5,
    parameter int SPACE_W  = 11,
    parameter int AMT_W    = 9,
    parameter int LEN_W    = 6,
    parameter int TICK_W   = 8
) (
    input  logic                clk,
    input  logic                rst_n,
    sram_match_engine_if.slave  bus
);
    localparam int CMP_W = (SPACE_W > LEN_W + 1) ? SPACE_W : LEN_W + 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_SRAM - 1);
    localparam logic [IDX_W:0]   NO_SRAM  = (IDX_W + 1)'(NUM_SRAM);

    typedef enum logic [1:0] {IDLE, SCAN, DONE} state_t;

    state_t             state;
    logic [IDX_W-1:0]   ptr;
    logic [IDX_W-1:0]   start_ptr;
    logic [IDX_W-1:0]   ptr_nx;
    logic [TICK_W-1:0]  tick;
    logic               found;
    logic [1:0]         mode_r;
    logic [LEN_W-1:0]   len_r;
    logic [AMT_W-1:0]   best_amt;
    logic [SPACE_W-1:0] best_space;
    logic [IDX_W:0]     best_sram;
    logic               suc_r;
    logic               fail_r;
    logic [CMP_W-1:0]   space_c;
    logic [CMP_W-1:0]   need_c;
    logic               qualify;
    logic               take;
    logic               scan_end;

    // Widened compare so new_length+1 can never wrap against a narrow free_space.
    assign space_c = CMP_W'(bus.free_space);
    assign need_c  = CMP_W'(len_r) + CMP_W'(1);
    assign qualify = bus.accessible && (space_c >= need_c);
    assign ptr_nx  = (ptr == LAST_IDX) ? '0 : ptr + 1'b1;

    always_comb begin
        take = 1'b0;
        case (mode_r)
            2'd1:    take = qualify && (!found || bus.free_space > best_space);
            2'd2:    take = qualify && !found;
            default: take = qualify && (!found || bus.packet_amount >= best_amt);
        endcase
    end

    assign scan_end = (found && (tick >= bus.match_threshold || mode_r == 2'd2))
                    || (tick == bus.match_timeout);

    assign bus.probe_sram      = ptr;
    assign bus.match_busy      = (state != IDLE);
    assign bus.match_suc       = suc_r && !bus.match_abort;
    assign bus.match_fail      = fail_r && !bus.match_abort;
    assign bus.match_best_sram = best_sram;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state      <= IDLE;
            ptr        <= '0;
            start_ptr  <= '0;
            tick       <= '0;
            found      <= 1'b0;
            mode_r     <= '0;
            len_r      <= '0;
            best_amt   <= '0;
            best_space <= '0;
            best_sram  <= NO_SRAM;
            suc_r      <= 1'b0;
            fail_r     <= 1'b0;
        end else begin
            suc_r  <= 1'b0;
            fail_r <= 1'b0;
            case (state)
                IDLE: begin
                    if (bus.match_req) begin
                        mode_r     <= (bus.mode == 2'd3) ? 2'd0 : bus.mode;
                        len_r      <= bus.new_length;
                        ptr        <= start_ptr;
                        tick       <= '0;
                        found      <= 1'b0;
                        best_amt   <= '0;
                        best_space <= '0;
                        best_sram  <= NO_SRAM;
                        state      <= SCAN;
                    end
                end
                SCAN: begin
                    if (bus.match_abort) begin
                        state <= IDLE;
                    end else begin
                        ptr <= ptr_nx;
                        if (tick != '1)
                            tick <= tick + 1'b1;
                        if (take) begin
                            found      <= 1'b1;
                            best_sram  <= {1'b0, ptr};
                            best_amt   <= bus.packet_amount;
                            best_space <= bus.free_space;
                        end
                        // The candidate probed on the final tick still counts toward the result.
                        if (scan_end) begin
                            state  <= DONE;
                            suc_r  <= found || take;
                            fail_r <= !(found || take);
                        end
                    end
                end
                DONE: begin
                    state <= IDLE;
                    if (!bus.match_abort && suc_r)
                        start_ptr <= (best_sram[IDX_W-1:0] == LAST_IDX) ? '0
                                   : best_sram[IDX_W-1:0] + 1'b1;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_sram_match_engine.sv
// tb/tb_sram_match_engine.sv - table vectors, corner sequences and random scans against a scan model
module tb_sram_match_engine;
    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    sram_match_engine_if #(.IDX_W(5)) b32 ();
    sram_match_engine_if #(.IDX_W(3)) b5 ();

    sram_match_engine #(.NUM_SRAM(32), .IDX_W(5)) dut32 (.clk(clk), .rst_n(rst_n), .bus(b32.slave));
    sram_match_engine #(.NUM_SRAM(5),  .IDX_W(3)) dut5  (.clk(clk), .rst_n(rst_n), .bus(b5.slave));

    bit acc32[32];
    int fs32[32];
    int pa32[32];

    always_comb begin
        b32.accessible    = acc32[b32.probe_sram];
        b32.free_space    = 11'(fs32[b32.probe_sram]);
        b32.packet_amount = 9'(pa32[b32.probe_sram]);
        b5.accessible     = 1'b1;
        b5.free_space     = 11'd100;
        b5.packet_amount  = 9'(b5.probe_sram);
    end

    int n_pass = 0;
    int n_total = 0;

    task automatic check(input string name, input int act, input int exp);
        n_total++;
        if (act == exp) n_pass++;
        else $display("FAIL %s actual=%0d expected=%0d", name, act, exp);
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic set_pat(input int id);
        for (int i = 0; i < 32; i++) begin
            acc32[i] = 1'b1; fs32[i] = 100; pa32[i] = 0;
            case (id)
                0: pa32[i] = i;
                1: acc32[i] = 1'b0;
                2: fs32[i] = (i == 3 || i == 5) ? 500 : 50;
                3: acc32[i] = (i == 7);
                4: fs32[i] = (i == 2) ? 64 : 63;
                5: fs32[i] = 63;
                default: ;
            endcase
        end
    endtask

    task automatic run32(input int md, input int ln, input int th, input int to,
                         output int suc, output int best, output int endt);
        @(negedge clk);
        b32.mode = 2'(md); b32.new_length = 6'(ln);
        b32.match_threshold = 8'(th); b32.match_timeout = 8'(to);
        b32.match_req = 1'b1;
        @(negedge clk);
        b32.match_req = 1'b0;
        suc = 0; best = -1; endt = -1;
        for (int n = 0; n < 300; n++) begin
            if (b32.match_suc || b32.match_fail) begin
                suc = int'(b32.match_suc); best = int'(b32.match_best_sram); endt = n - 1;
                break;
            end
            @(negedge clk);
        end
        if (endt < 0) check("scan_never_ended", 0, 1);
        else begin
            @(negedge clk);
            check("pulse_single_cycle", int'(b32.match_suc | b32.match_fail | b32.match_busy), 0);
        end
    endtask

    function automatic void model(input int md, input int ln, input int th, input int to,
                                  input int st, output int suc, output int best, output int endt);
        int m, p, tk, bamt, bsp;
        bit found, fin, q;
        m = (md == 3) ? 0 : md;
        found = 0; bamt = 0; bsp = 0; best = 32; suc = 0; endt = -1;
        for (int t = 0; t < 300; t++) begin
            p = (st + t) % 32;
            tk = (t > 255) ? 255 : t;
            fin = (found && (tk >= th || m == 2)) || tk == to;
            q = acc32[p] && fs32[p] >= ln + 1;
            if (q && (!found || (m == 0 && pa32[p] >= bamt) || (m == 1 && fs32[p] > bsp))) begin
                found = 1; best = p; bamt = pa32[p]; bsp = fs32[p];
            end
            if (fin) begin
                suc = found; endt = t;
                return;
            end
        end
    endfunction

    typedef struct {
        int md; int ln; int th; int to; int pat;
        int suc; int best; int endt;
    } vec_t;
    vec_t vecs[11];

    initial begin
        int suc, best, endt, msuc, mbest, mend, start, hits, pr[32];
        vecs[0]  = '{0, 10, 4, 40, 0, 1, 4, 4};
        vecs[1]  = '{0, 10, 4, 10, 1, 0, 32, 10};
        vecs[2]  = '{1, 60, 2, 40, 2, 1, 3, 4};
        vecs[3]  = '{1, 60, 8, 40, 2, 1, 3, 8};
        vecs[4]  = '{2, 10, 20, 40, 3, 1, 7, 8};
        vecs[5]  = '{2, 63, 0, 40, 4, 1, 2, 3};
        vecs[6]  = '{0, 63, 0, 20, 5, 0, 32, 20};
        vecs[7]  = '{3, 10, 4, 40, 0, 1, 4, 4};
        vecs[8]  = '{0, 10, 5, 0, 0, 1, 0, 0};
        vecs[9]  = '{0, 10, 5, 0, 1, 0, 32, 0};
        vecs[10] = '{0, 10, 0, 40, 0, 1, 1, 1};

        b32.match_req = 0; b32.match_abort = 0; b32.mode = 0; b32.new_length = 0;
        b32.match_threshold = 0; b32.match_timeout = 0;
        b5.match_req = 0; b5.match_abort = 0; b5.mode = 0; b5.new_length = 10;
        b5.match_threshold = 7; b5.match_timeout = 40;
        set_pat(0);
        do_reset();

        check("reset_busy", int'(b32.match_busy), 0);
        check("reset_suc_fail", int'(b32.match_suc | b32.match_fail), 0);
        check("reset_best", int'(b32.match_best_sram), 32);
        check("reset_probe", int'(b32.probe_sram), 0);

        foreach (vecs[i]) begin
            do_reset();
            set_pat(vecs[i].pat);
            run32(vecs[i].md, vecs[i].ln, vecs[i].th, vecs[i].to, suc, best, endt);
            check($sformatf("vec%0d_suc", i), suc, vecs[i].suc);
            check($sformatf("vec%0d_best", i), best, vecs[i].best);
            check($sformatf("vec%0d_end_tick", i), endt, vecs[i].endt);
        end

        // Mode-1 success on SRAM 3 moves the next scan start to 4; aborts keep it there.
        do_reset();
        set_pat(2);
        run32(1, 60, 2, 40, suc, best, endt);
        for (int k = 0; k < 2; k++) begin
            @(negedge clk);
            b32.mode = 0; b32.match_threshold = 30; b32.match_timeout = 40; b32.match_req = 1;
            @(negedge clk);
            b32.match_req = 0;
            check("next_start_probe", int'(b32.probe_sram), 4);
            check("best_cleared_on_req", int'(b32.match_best_sram), 32);
            b32.match_abort = 1;
            @(negedge clk);
            b32.match_abort = 0;
            hits = 0;
            for (int c = 0; c < 4; c++) begin
                hits += int'(b32.match_busy | b32.match_suc | b32.match_fail);
                @(negedge clk);
            end
            check("abort_idle_no_pulse", hits, 0);
        end

        // Reset during a scan from start 4.
        b32.match_req = 1;
        @(negedge clk);
        b32.match_req = 0;
        repeat (3) @(negedge clk);
        rst_n = 0;
        @(negedge clk);
        check("midscan_rst_busy", int'(b32.match_busy), 0);
        check("midscan_rst_pulses", int'(b32.match_suc | b32.match_fail), 0);
        check("midscan_rst_best", int'(b32.match_best_sram), 32);
        check("midscan_rst_probe", int'(b32.probe_sram), 0);
        rst_n = 1;

        // Five-SRAM instance: pointer must wrap 4 -> 0.
        @(negedge clk);
        b5.match_req = 1;
        @(negedge clk);
        b5.match_req = 0;
        endt = -1;
        for (int n = 0; n < 32; n++) begin
            pr[n] = int'(b5.probe_sram);
            if (b5.match_suc) begin endt = n - 1; break; end
            @(negedge clk);
        end
        check("n5_probe_tick4", pr[4], 4);
        check("n5_probe_wrap", pr[5], 0);
        check("n5_end_tick", endt, 7);
        check("n5_best", int'(b5.match_best_sram), 4);

        // Random scans, start pointer tracked by the model across runs.
        do_reset();
        start = 0;
        for (int r = 0; r < 40; r++) begin
            int md, ln, th, to;
            for (int i = 0; i < 32; i++) begin
                acc32[i] = ($urandom_range(0, 3) != 0);
                fs32[i]  = $urandom_range(0, 80);
                pa32[i]  = $urandom_range(0, 15);
            end
            md = $urandom_range(0, 3); ln = $urandom_range(0, 63);
            th = $urandom_range(0, 20); to = $urandom_range(0, 40);
            model(md, ln, th, to, start, msuc, mbest, mend);
            run32(md, ln, th, to, suc, best, endt);
            check($sformatf("rnd%0d_suc", r), suc, msuc);
            check($sformatf("rnd%0d_best", r), best, mbest);
            check($sformatf("rnd%0d_end_tick", r), endt, mend);
            if (msuc != 0) start = (mbest + 1) % 32;
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule
